// File: rtl/neuron_layer_scheduler.sv
// Time-multiplexes one sequential MAC across all output neurons of a dense layer.
// Optional ReLU on the result write path: define SCHED_RELU_EN.
module neuron_layer_scheduler #(
  parameter int unsigned NUM_NEURONS    = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error,
  output logic                                  w_rd_en,
  output logic [$clog2(NUM_NEURONS):0]          w_addr,
  output logic                                  mac_valid_in,
  input  logic                                  mac_valid_out,
  input  logic signed [DATA_WIDTH-1:0]          mac_result,
  output logic                                  res_we,
  output logic [$clog2(NUM_NEURONS):0]          res_addr,
  output logic signed [DATA_WIDTH-1:0]          res_data
);

  localparam int unsigned AW = $clog2(NUM_NEURONS) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_FINISH
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [AW-1:0]                r_idx;
  logic [AW-1:0]                w_idx_next;
  logic [TW-1:0]                r_tmo;
  logic [TW-1:0]                w_tmo_next;
  logic                         w_timeout;
  logic                         w_accept;
  logic signed [DATA_WIDTH-1:0] w_result_wr;

  logic                         w_busy_d;
  logic                         w_done_d;
  logic                         w_error_d;
  logic                         w_rd_en_d;
  logic [AW-1:0]                w_waddr_d;
  logic                         w_mac_vin_d;
  logic                         w_res_we_d;
  logic [AW-1:0]                w_raddr_d;
  logic signed [DATA_WIDTH-1:0] w_rdata_d;

`ifdef SCHED_RELU_EN
  assign w_result_wr = mac_result[DATA_WIDTH-1] ? '0 : mac_result;
`else
  assign w_result_wr = mac_result;
`endif

  assign w_accept = (r_state == S_IDLE) && start;

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_tmo        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      w_rd_en      <= 1'b0;
      w_addr       <= '0;
      mac_valid_in <= 1'b0;
      res_we       <= 1'b0;
      res_addr     <= '0;
      res_data     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_tmo        <= w_tmo_next;
      busy         <= w_busy_d;
      done         <= w_done_d;
      error        <= w_error_d;
      w_rd_en      <= w_rd_en_d;
      w_addr       <= w_waddr_d;
      mac_valid_in <= w_mac_vin_d;
      res_we       <= w_res_we_d;
      res_addr     <= w_raddr_d;
      res_data     <= w_rdata_d;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_tmo_next   = r_tmo;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_FETCH;
          w_idx_next   = '0;
        end
      end
      S_FETCH: w_state_next = S_ISSUE;
      S_ISSUE: begin
        w_state_next = S_WAIT;
        w_tmo_next   = '0;
      end
      S_WAIT: begin
        // A result on the last allowed cycle still wins over the timeout
        if (mac_valid_out) begin
          w_state_next = S_WRITE;
        end else if (r_tmo == TMO_LAST) begin
          w_state_next = S_IDLE;
          w_timeout    = 1'b1;
        end else begin
          w_tmo_next = r_tmo + TW'(1);
        end
      end
      S_WRITE: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = S_FINISH;
        end else begin
          w_state_next = S_FETCH;
          w_idx_next   = r_idx + AW'(1);
        end
      end
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_comb begin
    w_busy_d    = (w_state_next == S_FETCH) || (w_state_next == S_ISSUE) ||
                  (w_state_next == S_WAIT)  || (w_state_next == S_WRITE);
    w_done_d    = (w_state_next == S_FINISH);
    w_rd_en_d   = (w_state_next == S_FETCH);
    w_mac_vin_d = (w_state_next == S_ISSUE);
    w_res_we_d  = (w_state_next == S_WRITE);
    w_error_d   = error;
    w_waddr_d   = w_addr;
    w_raddr_d   = res_addr;
    w_rdata_d   = res_data;
    if (w_accept) begin
      w_error_d = 1'b0;
    end
    if (w_timeout) begin
      w_error_d = 1'b1;
    end
    if (w_state_next == S_FETCH) begin
      w_waddr_d = w_idx_next;
    end
    if (w_state_next == S_WRITE) begin
      w_raddr_d = r_idx;
    end
    if ((r_state == S_WAIT) && mac_valid_out) begin
      w_rdata_d = w_result_wr;
    end
  end

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Self-checking bench for neuron_layer_scheduler: random MAC latencies/results
// against a cycle-count and write-list model derived from the layer schedule.
module tb_neuron_layer_scheduler;

  localparam int N      = 4;
  localparam int DW     = 16;
  localparam int TO     = 64;
  localparam int AW     = $clog2(N) + 1;
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, error, w_rd_en, mac_valid_in, res_we;
  logic [AW-1:0] w_addr, res_addr;
  logic [DW-1:0] res_data;
  logic          mac_valid_out;
  logic [DW-1:0] mac_result;
  logic          resp_v = 1'b0;
  logic [DW-1:0] resp_d = '0;
  logic          spur_v;
  logic [DW-1:0] spur_d;
  logic [6+2*AW+DW-1:0] outs;

  assign mac_valid_out = resp_v | spur_v;
  assign mac_result    = resp_v ? resp_d : spur_d;
  assign outs = {busy, done, error, w_rd_en, mac_valid_in, res_we, w_addr, res_addr, res_data};

  always #5 clk = ~clk;

  neuron_layer_scheduler #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .mac_valid_in(mac_valid_in),
    .mac_valid_out(mac_valid_out), .mac_result(mac_result), .res_we(res_we),
    .res_addr(res_addr), .res_data(res_data)
  );

  // Per-neuron MAC behaviour for the current pass
  int            lat  [N];
  logic [DW-1:0] val  [N];
  bit            mute [N];

  // MAC model: answers L cycles after the launch pulse, unless muted
  int            pend = 0;
  logic [DW-1:0] pend_d = '0;
  always @(negedge clk) begin
    resp_v = 1'b0;
    if (rst) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          resp_v = 1'b1;
          resp_d = pend_d;
        end
      end
      if (mac_valid_in && !mute[int'(w_addr)]) begin
        pend   = lat[int'(w_addr)];
        pend_d = val[int'(w_addr)];
      end
    end
  end

  typedef struct { int addr; logic [DW-1:0] data; longint t; } wr_t;
  wr_t    wq [$];
  longint dq [$];
  int     vin_cnt = 0;

  always begin
    @(posedge clk);
    #1;
    if (res_we) begin
      wr_t e;
      e.addr = int'(res_addr);
      e.data = res_data;
      e.t    = longint'($time);
      wq.push_back(e);
    end
    if (done) dq.push_back(longint'($time));
    if (mac_valid_in) vin_cnt++;
  end

  int     vecs = 0;
  int     errs = 0;
  int     wbase, dbase, vbase;
  longint t0;

  task automatic check(input string tag, input longint obs, input longint exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Schedule model: each neuron costs FETCH + ISSUE + L waits + WRITE
  function automatic int wr_cycle(int i);
    int c = 0;
    for (int j = 0; j <= i; j++) c += 3 + lat[j];
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_data(int i);
`ifdef SCHED_RELU_EN
    return val[i][DW-1] ? '0 : val[i];
`else
    return val[i];
`endif
  endfunction

  function automatic int to_cyc(longint t);
    return int'((t - t0 + 4) / 10);
  endfunction

  task automatic set_random(input int lmin, input int lmax);
    for (int i = 0; i < N; i++) begin
      lat[i]  = int'($urandom_range(lmax, lmin));
      val[i]  = DW'($urandom);
      mute[i] = 1'b0;
    end
  endtask

  task automatic mark();
    wbase = wq.size();
    dbase = dq.size();
    vbase = vin_cnt;
    t0    = longint'($time);
  endtask

  // Drives start at the current negedge and runs until busy drops (cycle 1 = FETCH)
  task automatic run_pass(input string tag, input int inject_k, input bit spur,
                          output int end_k, output bit end_done, output bit end_err);
    end_k = -1; end_done = 1'b0; end_err = 1'b0;
    mark();
    start  = 1'b1;
    spur_v = spur;
    spur_d = 16'h7ABC;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      start = (k == inject_k);
      if (k >= 2) spur_v = 1'b0;
      if (k == 1) begin
        check({tag, ".busy1"}, longint'(busy), 1);
        check({tag, ".err1"}, longint'(error), 0);
      end
      if (!busy) begin
        end_k    = k;
        end_done = done;
        end_err  = error;
        break;
      end
    end
    start  = 1'b0;
    spur_v = 1'b0;
  endtask

  task automatic check_pass(input string tag, input int n_wr, input bit exp_done, input int n_vin);
    int nw;
    nw = wq.size() - wbase;
    check({tag, ".nwr"}, longint'(nw), longint'(n_wr));
    for (int i = 0; i < nw && i < n_wr; i++) begin
      wr_t e;
      e = wq[wbase + i];
      check({tag, ".addr"}, longint'(e.addr), longint'(i));
      check({tag, ".data"}, longint'(e.data), longint'(exp_data(i)));
      check({tag, ".wcyc"}, longint'(to_cyc(e.t)), longint'(wr_cycle(i)));
    end
    check({tag, ".ndone"}, longint'(dq.size() - dbase), exp_done ? 1 : 0);
    if (exp_done && dq.size() > dbase)
      check({tag, ".dcyc"}, longint'(to_cyc(dq[dbase])), longint'(wr_cycle(N - 1) + 1));
    check({tag, ".nvin"}, longint'(vin_cnt - vbase), longint'(n_vin));
  endtask

  task automatic full_pass(input string tag, input int inject_k, input bit spur);
    int ek; bit ed, ee;
    run_pass(tag, inject_k, spur, ek, ed, ee);
    check({tag, ".end"}, longint'(ek), longint'(wr_cycle(N - 1) + 1));
    check({tag, ".done"}, longint'(ed), 1);
    check({tag, ".err"}, longint'(ee), 0);
    check_pass(tag, N, 1'b1, N);
  endtask

  initial begin
    int ek; bit ed, ee; int k_rst;
    rst = 1'b1; start = 1'b0; spur_v = 1'b0; spur_d = '0;
    for (int i = 0; i < N; i++) begin lat[i] = 1; val[i] = '0; mute[i] = 1'b0; end
    repeat (2) @(negedge clk);
    check("reset.outs", longint'(outs), 0);
    rst = 1'b0;
    @(negedge clk);

    // Spurious MAC valid while idle
    mark();
    spur_v = 1'b1; spur_d = 16'h1234;
    @(negedge clk);
    spur_v = 1'b0;
    @(negedge clk);
    check("spur_idle.we", longint'(wq.size() - wbase), 0);
    check("spur_idle.busy", longint'(busy), 0);

    // Directed pass: L=5, results 10,20,30,40
    for (int i = 0; i < N; i++) begin lat[i] = 5; val[i] = DW'(10 * (i + 1)); end
    full_pass("dir", 0, 1'b0);

    // Start during FINISH is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("finish_start.busy", longint'(busy), 0);

    // First IDLE cycle after FINISH: accepted; neuron 2 returns -7
    set_random(1, 12);
    val[2] = 16'hFFF9;
    full_pass("neg", 0, 1'b0);
    @(negedge clk);

    // Second start during neuron 1 WAIT
    set_random(2, 12);
    full_pass("busy_start", 3 + lat[0] + 3, 1'b0);
    @(negedge clk);

    // Timeout on neuron 1
    set_random(1, 12);
    mute[1] = 1'b1;
    run_pass("tmo", 0, 1'b0, ek, ed, ee);
    check("tmo.end", longint'(ek), longint'(wr_cycle(0) + 2 + TO + 1));
    check("tmo.err", longint'(ee), 1);
    check("tmo.done", longint'(ed), 0);
    check_pass("tmo", 1, 1'b0, 2);

    // Next start clears error and runs a full pass
    set_random(1, 12);
    full_pass("clr", 0, 1'b0);
    @(negedge clk);

    // Reset during neuron 2 WAIT
    set_random(2, 12);
    mark();
    k_rst = wr_cycle(1) + 4;
    start = 1'b1;
    for (int k = 1; k <= k_rst; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rst_mid.outs", longint'(outs), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_mid.nwr", longint'(wq.size() - wbase), 2);
    check("rst_mid.ndone", longint'(dq.size() - dbase), 0);
    @(negedge clk);
    set_random(1, 12);
    full_pass("post_rst", 0, 1'b0);
    @(negedge clk);

    // Spurious MAC valid in the start cycle and in FETCH
    set_random(1, 12);
    full_pass("spur_fetch", 0, 1'b1);
    @(negedge clk);

    // Random passes
    for (int r = 0; r < 6; r++) begin
      set_random(1, 20);
      full_pass("rand", 0, 1'b0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
